// File: rtl/mem_req_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters, the arbiter and the memory controller.
// The arbiter uses the slave view; the environment/requester side uses master.
interface mem_req_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]     in_valid;
    logic [NUM_REQ-1:0]     in_write;
    logic [NUM_REQ*32-1:0]  in_addr;
    logic [NUM_REQ*256-1:0] in_wdata;
    logic [NUM_REQ*3-1:0]   in_qos;
    logic [NUM_REQ-1:0]     in_ready;

    logic                   mc_req_valid;
    logic                   mc_req_write;
    logic [31:0]            mc_req_addr;
    logic [255:0]           mc_req_wdata;
    logic [2:0]             mc_req_qos;
    logic                   mc_req_ready;

    logic                   mc_rsp_valid;
    logic [255:0]           mc_rsp_data;
    logic                   mc_rsp_error;
    logic                   mc_rsp_ready;

    logic [NUM_REQ-1:0]     rsp_valid;
    logic [255:0]           rsp_data;
    logic                   rsp_error;
    logic [NUM_REQ-1:0]     rsp_ready;

    logic                   protocol_err;

    modport slave (
        input  in_valid, in_write, in_addr, in_wdata, in_qos,
        output in_ready,
        output mc_req_valid, mc_req_write, mc_req_addr, mc_req_wdata, mc_req_qos,
        input  mc_req_ready,
        input  mc_rsp_valid, mc_rsp_data, mc_rsp_error,
        output mc_rsp_ready,
        output rsp_valid, rsp_data, rsp_error,
        input  rsp_ready,
        output protocol_err
    );

    modport master (
        output in_valid, in_write, in_addr, in_wdata, in_qos,
        input  in_ready,
        input  mc_req_valid, mc_req_write, mc_req_addr, mc_req_wdata, mc_req_qos,
        output mc_req_ready,
        output mc_rsp_valid, mc_rsp_data, mc_rsp_error,
        input  mc_rsp_ready,
        input  rsp_valid, rsp_data, rsp_error,
        output rsp_ready,
        input  protocol_err
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// QoS arbiter with age-based urgency and round-robin tie-break in front of one memory port.
// Read IDs are queued in issue order so responses are routed back to their requester.
module mem_req_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned AGE_LIMIT      = 15,
    parameter int unsigned RD_OUTSTANDING = 8
) (
    input logic              clk,
    input logic              rst,
    mem_req_arbiter_if.slave bus
);
    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned AgeW = $clog2(AGE_LIMIT + 1);
    localparam int unsigned PtrW = (RD_OUTSTANDING > 1) ? $clog2(RD_OUTSTANDING) : 1;
    localparam int unsigned CntW = $clog2(RD_OUTSTANDING + 1);

    logic [AgeW-1:0]    age_q [NUM_REQ];
    logic [AgeW-1:0]    age_d [NUM_REQ];
    logic [IdxW-1:0]    rr_q, rr_d;
    logic [IdxW-1:0]    fifo_q [RD_OUTSTANDING];
    logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]    rd_count_q;
    logic               perr_q;
    logic               req_valid_q, req_write_q;
    logic [31:0]        req_addr_q;
    logic [255:0]       req_wdata_q;
    logic [2:0]         req_qos_q;

    logic               slot_free, fifo_empty, rsp_pop, rd_room, rd_push;
    logic [IdxW-1:0]    head, cand, gnt_idx;
    logic               gnt_found;
    logic [3:0]         best_prio;
    logic [3:0]         prio [NUM_REQ];
    logic [NUM_REQ-1:0] elig, grant, rsp_valid;
    logic               sel_write;
    logic [31:0]        sel_addr;
    logic [255:0]       sel_wdata;
    logic [2:0]         sel_qos;

    assign slot_free  = !req_valid_q || bus.mc_req_ready;
    assign fifo_empty = (rd_count_q == '0);
    assign head       = fifo_q[rd_ptr_q];
    assign rsp_pop    = bus.mc_rsp_valid && !fifo_empty && bus.rsp_ready[head];
    // A response popping this cycle frees a slot for a read granted in the same cycle.
    assign rd_room    = (rd_count_q < CntW'(RD_OUTSTANDING)) || rsp_pop;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = !rst && slot_free && bus.in_valid[i] && (bus.in_write[i] || rd_room);
            prio[i] = (age_q[i] >= AgeW'(AGE_LIMIT)) ? 4'd8 : {1'b0, bus.in_qos[3*i +: 3]};
        end
    end

    // Scan from rr_q; a strictly higher priority replaces the pick, so ties keep the first.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        best_prio = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IdxW'((32'(rr_q) + k) % NUM_REQ);
            if (elig[cand] && (!gnt_found || prio[cand] > best_prio)) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
                best_prio = prio[cand];
            end
        end
    end

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_qos   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = gnt_found && (gnt_idx == IdxW'(i));
            if (grant[i]) begin
                sel_write = bus.in_write[i];
                sel_addr  = bus.in_addr[32*i +: 32];
                sel_wdata = bus.in_wdata[256*i +: 256];
                sel_qos   = prio[i][3] ? 3'd7 : bus.in_qos[3*i +: 3];
            end
        end
    end

    assign rd_push = gnt_found && !sel_write;
    assign rr_d    = (gnt_idx == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!bus.in_valid[i] || grant[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] < AgeW'(AGE_LIMIT)) begin
                age_d[i] = age_q[i] + 1'b1;
            end else begin
                age_d[i] = age_q[i];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (!fifo_empty) begin
            rsp_valid[head] = bus.mc_rsp_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid_q <= 1'b0;
            rr_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_count_q  <= '0;
            perr_q      <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) age_q[i] <= '0;
        end else begin
            if (gnt_found) begin
                req_valid_q <= 1'b1;
                rr_q        <= rr_d;
            end else if (bus.mc_req_ready) begin
                req_valid_q <= 1'b0;
            end
            if (rd_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rsp_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({rd_push, rsp_pop})
                2'b10:   rd_count_q <= rd_count_q + 1'b1;
                2'b01:   rd_count_q <= rd_count_q - 1'b1;
                default: rd_count_q <= rd_count_q;
            endcase
            if (bus.mc_rsp_valid && fifo_empty) perr_q <= 1'b1;
            for (int i = 0; i < NUM_REQ; i++) age_q[i] <= age_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_found) begin
            req_write_q <= sel_write;
            req_addr_q  <= sel_addr;
            req_wdata_q <= sel_wdata;
            req_qos_q   <= sel_qos;
        end
        if (rd_push) fifo_q[wr_ptr_q] <= gnt_idx;
    end

    assign bus.in_ready     = grant;
    assign bus.mc_req_valid = req_valid_q;
    assign bus.mc_req_write = req_write_q;
    assign bus.mc_req_addr  = req_addr_q;
    assign bus.mc_req_wdata = req_wdata_q;
    assign bus.mc_req_qos   = req_qos_q;
    // Empty FIFO: accept and drop the stray beat.
    assign bus.mc_rsp_ready = fifo_empty ? 1'b1 : bus.rsp_ready[head];
    assign bus.rsp_valid    = rsp_valid;
    assign bus.rsp_data     = bus.mc_rsp_data;
    assign bus.rsp_error    = bus.mc_rsp_error;
    assign bus.protocol_err = perr_q;
endmodule
